// File: rtl/watch_fnd_display_if.sv
// Bus between the watch core / board and the FND display block.
// There is no valid/ready handshake on this bus: every i_* signal is sampled
// each clock, and o_frame_done is a one-cycle strobe that nothing can stall.
interface watch_fnd_display_if #(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
);
  logic                   i_disp_en;
  logic [P_COUNT_BIT-1:0] i_scan_div;
  logic [P_SEC_BIT-1:0]   i_sec;
  logic [P_MIN_BIT-1:0]   i_min;
  logic [P_HOUR_BIT-1:0]  i_hour;
  logic [5:0]             o_digit_sel;
  logic [6:0]             o_seg;
  logic                   o_dp;
  logic                   o_frame_done;
  // Debug view of the FSM: 1 while scanning, 0 while idle.
  logic                   o_scanning;

  modport master (
    output i_disp_en, i_scan_div, i_sec, i_min, i_hour,
    input  o_digit_sel, o_seg, o_dp, o_frame_done, o_scanning
  );

  modport slave (
    input  i_disp_en, i_scan_div, i_sec, i_min, i_hour,
    output o_digit_sel, o_seg, o_dp, o_frame_done, o_scanning
  );
endinterface

// File: rtl/watch_fnd_display.sv
// Six-digit HH.MM.SS multiplexed 7-segment driver. The time is snapshotted
// at scan start and again at every frame wrap so one frame never mixes two
// different seconds. All outputs are registered from next-state values.
module watch_fnd_display #(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  watch_fnd_display_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  localparam logic [P_COUNT_BIT-1:0] CNT_ONE = {{(P_COUNT_BIT-1){1'b0}}, 1'b1};
  localparam logic [6:0]             SEG_DASH = 7'h40;

  state_t                 state_q, state_d;
  logic [P_COUNT_BIT-1:0] cnt_q, cnt_d, n_m1;
  logic [2:0]             idx_q, idx_d;
  logic [P_SEC_BIT-1:0]   snap_sec_q, snap_sec_d;
  logic [P_MIN_BIT-1:0]   snap_min_q, snap_min_d;
  logic [P_HOUR_BIT-1:0]  snap_hour_q, snap_hour_d;
  logic                   tick, wrap, load;
  logic [5:0]             sel_d;
  logic [6:0]             seg_d;
  logic                   dp_d, fd_d;
  logic [6:0]             sec7, min7, hour7;
  logic                   sec_bad, min_bad, hour_bad;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  function automatic logic [6:0] tens7(input logic [6:0] v);
    tens7 = seg7(4'(v / 7'd10));
  endfunction

  function automatic logic [6:0] ones7(input logic [6:0] v);
    ones7 = seg7(4'(v % 7'd10));
  endfunction

  // State register; reset overrides the enable.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state follows the enable directly in both states.
  always_comb begin
    state_d = bus.i_disp_en ? S_SCAN : S_IDLE;
  end

  // Divider, digit index and snapshot reload. N of 0 or 1 both mean tick every cycle.
  always_comb begin
    n_m1        = (bus.i_scan_div > CNT_ONE) ? (bus.i_scan_div - CNT_ONE) : '0;
    tick        = (state_q == S_SCAN) && (cnt_q >= n_m1);
    wrap        = tick && (idx_q == 3'd5);
    cnt_d       = '0;
    idx_d       = 3'd0;
    load        = 1'b0;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    snap_hour_d = snap_hour_q;
    if (state_d == S_SCAN) begin
      if (state_q == S_IDLE) begin
        load = 1'b1;
      end else if (tick) begin
        idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        load  = wrap;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        idx_d = idx_q;
      end
    end
    if (load) begin
      snap_sec_d  = bus.i_sec;
      snap_min_d  = bus.i_min;
      snap_hour_d = bus.i_hour;
    end
  end

  // Next-cycle outputs from the next index and next snapshot.
  always_comb begin
    sec7     = 7'(snap_sec_d);
    min7     = 7'(snap_min_d);
    hour7    = 7'(snap_hour_d);
    sec_bad  = sec7 > 7'd59;
    min_bad  = min7 > 7'd59;
    hour_bad = hour7 > 7'd23;
    sel_d    = 6'd0;
    seg_d    = 7'd0;
    dp_d     = 1'b0;
    fd_d     = 1'b0;
    if (state_d == S_SCAN) begin
      sel_d = 6'b000001 << idx_d;
      case (idx_d)
        3'd0:    seg_d = sec_bad  ? SEG_DASH : ones7(sec7);
        3'd1:    seg_d = sec_bad  ? SEG_DASH : tens7(sec7);
        3'd2:    seg_d = min_bad  ? SEG_DASH : ones7(min7);
        3'd3:    seg_d = min_bad  ? SEG_DASH : tens7(min7);
        3'd4:    seg_d = hour_bad ? SEG_DASH : ones7(hour7);
        3'd5:    seg_d = hour_bad ? SEG_DASH : tens7(hour7);
        default: seg_d = 7'd0;
      endcase
      // Separators blink with the seconds count (lit on even seconds).
      dp_d = ((idx_d == 3'd2) || (idx_d == 3'd4)) && !snap_sec_d[0];
      fd_d = (state_q == S_SCAN) && wrap;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q            <= '0;
      idx_q            <= 3'd0;
      snap_sec_q       <= '0;
      snap_min_q       <= '0;
      snap_hour_q      <= '0;
      bus.o_digit_sel  <= 6'd0;
      bus.o_seg        <= 7'd0;
      bus.o_dp         <= 1'b0;
      bus.o_frame_done <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      snap_sec_q       <= snap_sec_d;
      snap_min_q       <= snap_min_d;
      snap_hour_q      <= snap_hour_d;
      bus.o_digit_sel  <= sel_d;
      bus.o_seg        <= seg_d;
      bus.o_dp         <= dp_d;
      bus.o_frame_done <= fd_d;
    end
  end

  assign bus.o_scanning = (state_q == S_SCAN);

endmodule

// File: tb/tb_watch_fnd_display.sv
// Directed testbench for watch_fnd_display: scan order, segment codes,
// separator blink, snapshot hold, fast scan, dashes, disable and reset.
module tb_watch_fnd_display;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [6:0] exp_q[$];

  watch_fnd_display_if bus ();

  watch_fnd_display dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: drop enable for one cycle, load new settings, raise enable and
  // return in the first cycle the new scan is visible.
  task automatic restart(input int n, input int h, input int m, input int s);
    bus.i_disp_en  = 1'b0;
    bus.i_scan_div = 30'(n);
    bus.i_hour     = 5'(h);
    bus.i_min      = 6'(m);
    bus.i_sec      = 6'(s);
    @(negedge clk);
    bus.i_disp_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.i_disp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.o_digit_sel !== 6'd0) begin errors++; $display("FAIL reset_sel got %b want 000000", bus.o_digit_sel); end
    checks++; if (bus.o_seg !== 7'd0) begin errors++; $display("FAIL reset_seg got %h want 00", bus.o_seg); end
    checks++; if (bus.o_dp !== 1'b0) begin errors++; $display("FAIL reset_dp got %b want 0", bus.o_dp); end
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", bus.o_frame_done); end
    checks++; if (bus.o_scanning !== 1'b0) begin errors++; $display("FAIL reset_state got %b want 0", bus.o_scanning); end
    reset = 1'b0;
  endtask

  // 12:34:56, N=4: two full frames via the expected-segment queue.
  task automatic test_basic_scan();
    logic [6:0] tbl [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [6:0] e;
    logic [5:0] e_sel;
    int idx;
    restart(4, 12, 34, 56);
    for (int c = 0; c < 48; c++) begin
      idx   = (c / 4) % 6;
      e_sel = 6'b000001 << idx;
      exp_q.push_back(tbl[idx]);
      e = exp_q.pop_front();
      checks++; if (bus.o_digit_sel !== e_sel) begin errors++; $display("FAIL basic_sel c=%0d got %b want %b", c, bus.o_digit_sel, e_sel); end
      checks++; if (bus.o_seg !== e) begin errors++; $display("FAIL basic_seg c=%0d got %h want %h", c, bus.o_seg, e); end
      checks++; if (bus.o_dp !== (idx == 2 || idx == 4)) begin errors++; $display("FAIL basic_dp c=%0d got %b want %b", c, bus.o_dp, (idx == 2 || idx == 4)); end
      checks++; if (bus.o_frame_done !== (c == 24)) begin errors++; $display("FAIL basic_fd c=%0d got %b want %b", c, bus.o_frame_done, (c == 24)); end
      @(negedge clk);
    end
  endtask

  // Seconds change 56->57 mid-frame: only visible from the next frame on.
  task automatic test_snapshot_hold();
    logic [6:0] f0 [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [6:0] f1 [6] = '{7'h07, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [6:0] e;
    logic       e_dp;
    int idx;
    restart(4, 12, 34, 56);
    for (int c = 0; c < 48; c++) begin
      idx  = (c / 4) % 6;
      e    = (c < 24) ? f0[idx] : f1[idx];
      e_dp = (c < 24) && (idx == 2 || idx == 4);
      checks++; if (bus.o_seg !== e) begin errors++; $display("FAIL hold_seg c=%0d got %h want %h", c, bus.o_seg, e); end
      checks++; if (bus.o_dp !== e_dp) begin errors++; $display("FAIL hold_dp c=%0d got %b want %b", c, bus.o_dp, e_dp); end
      checks++; if (bus.o_frame_done !== (c == 24)) begin errors++; $display("FAIL hold_fd c=%0d got %b want %b", c, bus.o_frame_done, (c == 24)); end
      if (c == 5) bus.i_sec = 6'd57;
      @(negedge clk);
    end
  endtask

  // N=0 and N=1 both give one digit per cycle.
  task automatic test_fast_scan();
    logic [6:0] tbl [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [5:0] e_sel;
    int idx;
    for (int n = 0; n < 2; n++) begin
      restart(n, 12, 34, 56);
      for (int c = 0; c < 18; c++) begin
        idx   = c % 6;
        e_sel = 6'b000001 << idx;
        checks++; if (bus.o_digit_sel !== e_sel) begin errors++; $display("FAIL fast_sel n=%0d c=%0d got %b want %b", n, c, bus.o_digit_sel, e_sel); end
        checks++; if (bus.o_seg !== tbl[idx]) begin errors++; $display("FAIL fast_seg n=%0d c=%0d got %h want %h", n, c, bus.o_seg, tbl[idx]); end
        checks++; if (bus.o_frame_done !== (c > 0 && idx == 0)) begin errors++; $display("FAIL fast_fd n=%0d c=%0d got %b want %b", n, c, bus.o_frame_done, (c > 0 && idx == 0)); end
        @(negedge clk);
      end
    end
  endtask

  // 24:60:05 -> hours and minutes dashed, seconds shown.
  task automatic test_out_of_range();
    logic [6:0] tbl [6] = '{7'h6D, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40};
    int idx;
    restart(2, 24, 60, 5);
    for (int c = 0; c < 12; c++) begin
      idx = (c / 2) % 6;
      checks++; if (bus.o_seg !== tbl[idx]) begin errors++; $display("FAIL range_seg c=%0d got %h want %h", c, bus.o_seg, tbl[idx]); end
      checks++; if (bus.o_dp !== 1'b0) begin errors++; $display("FAIL range_dp c=%0d got %b want 0", c, bus.o_dp); end
      @(negedge clk);
    end
  endtask

  // Drop enable during digit 3, then re-enable with a new time.
  task automatic test_disable();
    logic [5:0] e_sel;
    restart(3, 12, 34, 56);
    for (int c = 0; c < 10; c++) begin
      e_sel = 6'b000001 << (c / 3);
      checks++; if (bus.o_digit_sel !== e_sel) begin errors++; $display("FAIL dis_sel c=%0d got %b want %b", c, bus.o_digit_sel, e_sel); end
      if (c == 9) bus.i_disp_en = 1'b0;
      @(negedge clk);
    end
    checks++; if (bus.o_digit_sel !== 6'd0) begin errors++; $display("FAIL dis_off_sel got %b want 000000", bus.o_digit_sel); end
    checks++; if (bus.o_seg !== 7'd0) begin errors++; $display("FAIL dis_off_seg got %h want 00", bus.o_seg); end
    checks++; if (bus.o_scanning !== 1'b0) begin errors++; $display("FAIL dis_off_state got %b want 0", bus.o_scanning); end
    bus.i_hour    = 5'd1;
    bus.i_min     = 6'd2;
    bus.i_sec     = 6'd3;
    bus.i_disp_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_digit_sel !== 6'b000001) begin errors++; $display("FAIL dis_on_sel got %b want 000001", bus.o_digit_sel); end
    checks++; if (bus.o_seg !== 7'h4F) begin errors++; $display("FAIL dis_on_seg got %h want 4f", bus.o_seg); end
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++; $display("FAIL dis_on_fd got %b want 0", bus.o_frame_done); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.o_digit_sel !== 6'b000010) begin errors++; $display("FAIL dis_d1_sel got %b want 000010", bus.o_digit_sel); end
    checks++; if (bus.o_seg !== 7'h3F) begin errors++; $display("FAIL dis_d1_seg got %h want 3f", bus.o_seg); end
  endtask

  // Reset mid-frame with enable held high, then restart at digit 0.
  task automatic test_reset_mid();
    logic [5:0] e_sel;
    restart(2, 12, 34, 56);
    for (int c = 0; c < 6; c++) begin
      e_sel = 6'b000001 << (c / 2);
      checks++; if (bus.o_digit_sel !== e_sel) begin errors++; $display("FAIL rst_pre_sel c=%0d got %b want %b", c, bus.o_digit_sel, e_sel); end
      if (c == 5) reset = 1'b1;
      @(negedge clk);
    end
    checks++; if (bus.o_digit_sel !== 6'd0) begin errors++; $display("FAIL rst_sel got %b want 000000", bus.o_digit_sel); end
    checks++; if (bus.o_seg !== 7'd0) begin errors++; $display("FAIL rst_seg got %h want 00", bus.o_seg); end
    checks++; if (bus.o_dp !== 1'b0) begin errors++; $display("FAIL rst_dp got %b want 0", bus.o_dp); end
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 13; c++) begin
      e_sel = 6'b000001 << ((c / 2) % 6);
      checks++; if (bus.o_digit_sel !== e_sel) begin errors++; $display("FAIL rst_post_sel c=%0d got %b want %b", c, bus.o_digit_sel, e_sel); end
      checks++; if (bus.o_frame_done !== (c == 12)) begin errors++; $display("FAIL rst_post_fd c=%0d got %b want %b", c, bus.o_frame_done, (c == 12)); end
      @(negedge clk);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.i_disp_en  = 1'b0;
    bus.i_scan_div = '0;
    bus.i_sec      = '0;
    bus.i_min      = '0;
    bus.i_hour     = '0;
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_snapshot_hold();
    test_fast_scan();
    test_out_of_range();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
